// File: rtl/clk_div_sched.sv
// clk_div_sched: glitch-free divided clock with edge strobes, req/ack ratio change and run/stop.
// Optional CLK_DIV_SCHED_CNT_EN adds a 16-bit rise counter output edge_cnt.
module clk_div_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       div_sel,
  input  logic [CNT_W-1:0] div_half,
  input  logic             sel_req,
  output logic             sel_ack,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             active
`ifdef CLK_DIV_SCHED_CNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_h, w_h, w_h_sel;
  logic r_clk, w_clk, r_blk, w_req, w_tog, w_rise, w_fall, w_ack;
  assign w_h_sel = div_sel == 2'd0 ? CNT_W'(1) :
                   div_sel == 2'd1 ? CNT_W'(2) :
                   div_sel == 2'd2 ? CNT_W'(4) :
                   div_half == '0  ? CNT_W'(1) : div_half;
  // a held request is ignored after its ack until sel_req drops
  assign w_req  = sel_req & ~r_blk;
  assign w_tog  = (r_state != IDLE) && (r_cnt == r_h - CNT_W'(1));
  assign w_rise = w_tog & ~r_clk;
  assign w_fall = w_tog & r_clk;
  assign active = r_state != IDLE;
  assign clk_out = r_clk;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_clk   = r_clk;
    w_h     = r_h;
    w_ack   = 1'b0;
    if (r_state == IDLE) begin
      w_cnt = '0;
      w_clk = 1'b0;
      w_state = run ? RUN : IDLE;
      w_ack = w_req;
      w_h = w_req ? w_h_sel : r_h;
    end else begin
      w_cnt = w_tog ? '0 : r_cnt + CNT_W'(1);
      w_clk = r_clk ^ w_tog;
      w_ack = w_fall & w_req;
      w_h = w_ack ? w_h_sel : r_h;
      if (r_state == RUN && !run) w_state = STOP;
      else if (r_state == STOP && run) w_state = RUN;
      else if (r_state == STOP && w_fall) w_state = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clk     <= 1'b0;
      r_h       <= CNT_W'(1);
      r_blk     <= 1'b0;
      sel_ack   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_clk     <= w_clk;
      r_h       <= w_h;
      r_blk     <= w_ack ? 1'b1 : (sel_req ? r_blk : 1'b0);
      sel_ack   <= w_ack;
      rise_tick <= w_rise;
      fall_tick <= w_fall;
    end
  end
`ifdef CLK_DIV_SCHED_CNT_EN
  logic [15:0] r_edge_cnt;
  assign edge_cnt = r_edge_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_edge_cnt <= '0;
    else if (w_rise) r_edge_cnt <= r_edge_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/clk_div_sched.md
# clk_div_sched

Clock-divider scheduler that derives a glitch-free divided clock and single-cycle edge strobes from the 100 MHz system clock. It replaces free-running `always #N` clock generation with a synthesizable, software-controlled source of the 50 MHz and 25 MHz domains, plus slower and custom rates. A req/ack handshake switches ratios, and a run/stop control starts and stops the output; both change only on safe clock boundaries.

## Interface
- `CNT_W`, default 8: width of the half-period counter and of `div_half`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = generate divided clock, 0 = stop at the next low boundary.
- `div_sel`  in  2  ratio select: 0 → H=1 (÷2), 1 → H=2 (÷4), 2 → H=4 (÷8), 3 → H=`div_half` (custom).
- `div_half`  in  CNT_W  custom half-period in clk cycles; 0 is treated as 1.
- `sel_req`  in  1  ratio-change request; held high until `sel_ack`.
- `sel_ack`  out  1  one-cycle pulse when the new ratio takes effect.
- `clk_out`  out  1  registered divided clock; 50 % duty, period 2·H clk cycles.
- `rise_tick`  out  1  one-cycle strobe, high in the first cycle `clk_out` reads 1.
- `fall_tick`  out  1  one-cycle strobe, high in the first cycle `clk_out` reads 0 after a high phase.
- `active`  out  1  high in RUN or STOP.

## Operation
- State machine has three states:
  - IDLE: `clk_out`=0, `cnt`=0.
  - RUN: counting.
  - STOP: counting, draining to a low boundary.
- Transitions:
  - IDLE & `run` → RUN, with `cnt`=0 and `clk_out`=0.
  - RUN & !`run` → STOP.
  - STOP & `run` → RUN, with no phase change.
  - STOP at a falling toggle → IDLE.
- Counting in RUN/STOP:
  - If `cnt`==H−1: `cnt`←0 and `clk_out`←~`clk_out`.
  - Otherwise `cnt`←`cnt`+1.
  - The comparison is unsigned at CNT_W bits.
- The active half-period H is held in register `h_cur`. Reset value is 1.
- Ratio change:
  - In IDLE, `sel_req` is applied on the next edge. `h_cur` is loaded from `div_sel`/`div_half` and `sel_ack` pulses.
  - In RUN/STOP, `sel_req` is applied only at the edge where `clk_out` toggles 1→0. `h_cur` is loaded, `cnt`←0 and `sel_ack` pulses on that same edge.
  - No high phase is ever shortened or stretched.
- The requester must keep `div_sel`/`div_half` stable while `sel_req` is high. They are sampled at the apply edge.
- If `sel_req` is still high in the cycle `sel_ack` is high, it is not a new request. A new request requires `sel_req` low for at least one cycle.
- Simultaneous ratio change and stop at the same falling boundary:
  - Both take effect on that edge.
  - `sel_ack` pulses, the state goes to IDLE, and `h_cur` holds the new H.
- `active` is combinational from the state register.

## Timing
- Reset values:
  - `clk_out`, `rise_tick`, `fall_tick`, `sel_ack` and `active` are 0.
  - State is IDLE, `cnt`=0, `h_cur`=1.
- Reset mid-operation forces every reset value on the next edge. A truncated high phase of `clk_out` is acceptable under reset.
- Start latency: the first rise of `clk_out` occurs H edges after the edge that samples `run`=1 in IDLE.
- Steady state: `clk_out` toggles every H edges. With H=1 this gives 50 MHz and with H=2 it gives 25 MHz, from a 100 MHz `clk`.
- Tick strobes:
  - `rise_tick` and `fall_tick` are registered on the same edge as the matching `clk_out` toggle.
  - At H=1 they alternate every cycle.
- `sel_ack` latency:
  - IDLE: 1 edge.
  - RUN: up to 2·H edges, at the next falling toggle.
- Stop latency: `active` falls on the edge of the first falling toggle after `run` is sampled low. `clk_out` is already 0 at that point.
- Custom ratio: `div_half`=0 behaves exactly as `div_half`=1. The maximum is H=2^CNT_W−1.

## Configuration
- Macro: `CLK_DIV_SCHED_CNT_EN`.
- Defined:
  - Adds output `edge_cnt`, 16 bits, which counts `rise_tick` pulses.
  - `edge_cnt` is reset to 0 by `rst` and wraps from 0xFFFF to 0.
  - It holds its value in IDLE.
- Undefined: the `edge_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then `run`=1 with the default H=1:
  - `clk_out` rises 1 edge later and then toggles every cycle.
  - `rise_tick` is high on alternate cycles.
  - `active`=1.
- In IDLE, assert `sel_req` with `div_sel`=1:
  - `sel_ack` pulses 1 edge later.
  - Then `run`=1 gives a `clk_out` period of 4 cycles with a 2-high/2-low pattern.
- Running at H=4, assert `sel_req` with `div_sel`=3 and `div_half`=3 during a high phase:
  - The current high phase completes its 4 cycles.
  - `sel_ack` coincides with the fall.
  - The next low/high phases are 3 cycles each.
- Running at H=2, drop `run` during a high phase:
  - `clk_out` finishes the high phase.
  - `active` clears on the falling edge, and `clk_out` then stays 0.
  - Re-assert `run`: the first rise comes 2 edges later.
- Running at H=2, assert `rst` for 1 cycle mid-high-phase:
  - All outputs are 0 next edge and the state is IDLE.
  - After `run`, H is back to 1.
- With `div_sel`=3 and `div_half`=0, plus `CLK_DIV_SCHED_CNT_EN` defined:
  - Output runs at H=1.
  - After 20 rises `edge_cnt`=20.
  - Preloaded near wrap, 0xFFFF+1 → 0.
